// File: rtl/reg_timer_unit.sv
// Prescaled 16-bit timer driven by a flat config bus, reporting through a flat status bus.
// Define TIMER_PWM_EN to build the PWM output; otherwise pwm_out is tied low.
module reg_timer_unit #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic [NUM_CFG*REG_WIDTH-1:0]    rw_regs,
  output logic [NUM_STATUS*REG_WIDTH-1:0] ro_regs,
  output logic                            irq,
  output logic                            pwm_out
);

  logic [7:0]  ctrl;
  logic [7:0]  presc;
  logic [15:0] top;
  logic [15:0] cmp;
  logic        ctrl_en;
  logic        ctrl_auto_reload;
  logic        ctrl_clr;
  logic        ctrl_capture;
  logic        unused_cfg;

  assign ctrl             = rw_regs[7:0];
  assign presc            = rw_regs[15:8];
  assign top              = rw_regs[31:16];
  assign cmp              = rw_regs[47:32];
  assign ctrl_en          = ctrl[0];
  assign ctrl_auto_reload = ctrl[1];
  assign ctrl_clr         = ctrl[2];
  assign ctrl_capture     = ctrl[3];
  assign unused_cfg       = ^rw_regs;

  logic [15:0] cnt;
  logic [7:0]  presc_cnt;
  logic [15:0] snap;
  logic [7:0]  ovf_cnt;
  logic        ovf_flag;
  logic        cmp_flag;
  logic        running;
  logic        en_d;
  logic        clr_d;
  logic        cap_d;

  logic        en_rise;
  logic        clr_rise;
  logic        cap_rise;
  logic        tick;
  logic        ovf_ev;
  logic        cmp_ev;
  logic [15:0] cnt_after_tick;
  logic [7:0]  ovf_cnt_next;
  logic        ovf_flag_next;
  logic        cmp_flag_next;

  assign en_rise  = ctrl_en & ~en_d;
  assign clr_rise = ctrl_clr & ~clr_d;
  assign cap_rise = ctrl_capture & ~cap_d;
  // Counting is gated by the live EN bit so clearing EN freezes cnt immediately.
  assign tick     = running & ctrl_en & (presc_cnt == presc);
  assign ovf_ev   = tick & (cnt >= top);
  assign cmp_ev   = tick & (cnt_after_tick == cmp);

  // Counter value that a tick would produce.
  always_comb begin
    cnt_after_tick = cnt;
    if (ovf_ev) begin
      if (ctrl_auto_reload) begin
        cnt_after_tick = 16'd0;
      end else begin
        cnt_after_tick = cnt;
      end
    end else if (tick) begin
      cnt_after_tick = cnt + 16'd1;
    end else begin
      cnt_after_tick = cnt;
    end
  end

  // Sticky flags and overflow counter; an event in the clear cycle survives the clear.
  always_comb begin
    ovf_cnt_next  = ovf_cnt;
    ovf_flag_next = ovf_flag;
    cmp_flag_next = cmp_flag;
    if (clr_rise) begin
      ovf_flag_next = ovf_ev;
      cmp_flag_next = cmp_ev;
      if (ovf_ev) begin
        ovf_cnt_next = 8'd1;
      end else begin
        ovf_cnt_next = 8'd0;
      end
    end else begin
      ovf_flag_next = ovf_flag | ovf_ev;
      cmp_flag_next = cmp_flag | cmp_ev;
      if (ovf_ev && (ovf_cnt != 8'hFF)) begin
        ovf_cnt_next = ovf_cnt + 8'd1;
      end else begin
        ovf_cnt_next = ovf_cnt;
      end
    end
  end

  // Timer state, edge detectors and interrupt pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 16'd0;
      presc_cnt <= 8'd0;
      snap      <= 16'd0;
      ovf_cnt   <= 8'd0;
      ovf_flag  <= 1'b0;
      cmp_flag  <= 1'b0;
      running   <= 1'b0;
      en_d      <= 1'b0;
      clr_d     <= 1'b0;
      cap_d     <= 1'b0;
      irq       <= 1'b0;
    end else if (ena) begin
      en_d     <= ctrl_en;
      clr_d    <= ctrl_clr;
      cap_d    <= ctrl_capture;
      irq      <= ovf_ev | cmp_ev;
      ovf_cnt  <= ovf_cnt_next;
      ovf_flag <= ovf_flag_next;
      cmp_flag <= cmp_flag_next;
      if (cap_rise) begin
        snap <= cnt;
      end
      if (!ctrl_en) begin
        running <= 1'b0;
      end else if (en_rise) begin
        running   <= 1'b1;
        cnt       <= 16'd0;
        presc_cnt <= 8'd0;
      end else if (running) begin
        cnt <= cnt_after_tick;
        if (tick) begin
          presc_cnt <= 8'd0;
        end else begin
          presc_cnt <= presc_cnt + 8'd1;
        end
        if (ovf_ev && !ctrl_auto_reload) begin
          running <= 1'b0;
        end
      end
    end else begin
      irq <= 1'b0;
    end
  end

`ifdef TIMER_PWM_EN
  logic pwm_pol;
  logic pwm_next;

  assign pwm_pol = ctrl[4];

  // Idle level is the polarity bit; while running, active while cnt is below CMP.
  always_comb begin
    pwm_next = pwm_pol;
    if (running) begin
      pwm_next = (cnt < cmp) ^ pwm_pol;
    end else begin
      pwm_next = pwm_pol;
    end
  end

  // Registered PWM output, frozen while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= 1'b0;
    end else if (ena) begin
      pwm_out <= pwm_next;
    end
  end
`else
  assign pwm_out = 1'b0;
`endif

  // Status bus packing; unused status registers read as zero.
  always_comb begin
    ro_regs        = {(NUM_STATUS*REG_WIDTH){1'b0}};
    ro_regs[7:0]   = {5'b00000, cmp_flag, ovf_flag, running};
    ro_regs[15:8]  = snap[7:0];
    ro_regs[23:16] = snap[15:8];
    ro_regs[31:24] = ovf_cnt;
  end

endmodule

// File: tb/tb_reg_timer_unit.sv
// Directed self-checking bench for reg_timer_unit; PWM checks follow TIMER_PWM_EN.
module tb_reg_timer_unit;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [63:0] rw_regs;
  logic [63:0] ro_regs;
  logic        irq;
  logic        pwm_out;

  int vectors;
  int miscompares;

  reg_timer_unit #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .rw_regs (rw_regs),
    .ro_regs (ro_regs),
    .irq     (irq),
    .pwm_out (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [7:0] c0, input logic [7:0] pr,
                         input logic [15:0] tp, input logic [15:0] cm);
    rw_regs = {16'h0000, cm, tp, pr, c0};
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    ena     = 1'b1;
    rw_regs = 64'd0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    ena     = 1'b1;
    rw_regs = {$urandom, $urandom};
    repeat (3) step();
    vectors++;
    if (ro_regs !== 64'd0) begin
      $display("FAIL reset_ro: got %h expected %h", ro_regs, 64'd0);
      miscompares++;
    end
    vectors++;
    if (irq !== 1'b0 || pwm_out !== 1'b0) begin
      $display("FAIL reset_out: got irq=%b pwm=%b expected 0 0", irq, pwm_out);
      miscompares++;
    end
    rst          = 1'b0;
    rw_regs[7:0] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (ro_regs !== 64'd0) begin
        $display("FAIL idle_ro: cycle %0d got %h expected %h", i, ro_regs, 64'd0);
        miscompares++;
      end
    end
  endtask

  task automatic test_auto_reload();
    apply_reset();
    set_cfg(8'h03, 8'd1, 16'd3, 16'hFFFF);
    for (int i = 1; i <= 41; i++) begin
      step();
      vectors++;
      if (irq !== ((i >= 9) && ((i - 9) % 8 == 0))) begin
        $display("FAIL ar_irq: cycle %0d got %b expected %b", i, irq,
                 ((i >= 9) && ((i - 9) % 8 == 0)));
        miscompares++;
      end
    end
    vectors++;
    if (ro_regs[31:24] !== 8'd5) begin
      $display("FAIL ar_ovf_cnt: got %0d expected 5", ro_regs[31:24]);
      miscompares++;
    end
    vectors++;
    if (ro_regs[7:0] !== 8'h03) begin
      $display("FAIL ar_ro0: got %h expected 03", ro_regs[7:0]);
      miscompares++;
    end
  endtask

  task automatic test_one_shot();
    apply_reset();
    set_cfg(8'h01, 8'd0, 16'd4, 16'hFFFF);
    for (int i = 1; i <= 12; i++) begin
      step();
      vectors++;
      if (irq !== (i == 6)) begin
        $display("FAIL os_irq: cycle %0d got %b expected %b", i, irq, (i == 6));
        miscompares++;
      end
    end
    vectors++;
    if (ro_regs[7:0] !== 8'h02 || ro_regs[31:24] !== 8'd1) begin
      $display("FAIL os_status: got ro0=%h ro3=%h expected 02 01", ro_regs[7:0], ro_regs[31:24]);
      miscompares++;
    end
    rw_regs[7:0] = 8'h09;
    step();
    vectors++;
    if (ro_regs[23:8] !== 16'h0004) begin
      $display("FAIL os_hold_cnt: got %h expected 0004", ro_regs[23:8]);
      miscompares++;
    end
    rw_regs[7:0] = 8'h00;
    step();
    rw_regs[7:0] = 8'h01;
    step();
    vectors++;
    if (ro_regs[7:0] !== 8'h03) begin
      $display("FAIL os_restart: got ro0=%h expected 03", ro_regs[7:0]);
      miscompares++;
    end
    rw_regs[7:0] = 8'h09;
    step();
    vectors++;
    if (ro_regs[23:8] !== 16'h0000) begin
      $display("FAIL os_restart_cnt: got %h expected 0000", ro_regs[23:8]);
      miscompares++;
    end
  endtask

  task automatic test_saturation_clear();
    apply_reset();
    set_cfg(8'h03, 8'd0, 16'd0, 16'hFFFF);
    repeat (300) step();
    vectors++;
    if (ro_regs[31:24] !== 8'hFF || ro_regs[7:0] !== 8'h03) begin
      $display("FAIL sat: got ro3=%h ro0=%h expected ff 03", ro_regs[31:24], ro_regs[7:0]);
      miscompares++;
    end
    rw_regs[7:0] = 8'h07;
    step();
    vectors++;
    if (ro_regs[31:24] !== 8'd1 || ro_regs[7:0] !== 8'h03) begin
      $display("FAIL clr_vs_ovf: got ro3=%h ro0=%h expected 01 03", ro_regs[31:24], ro_regs[7:0]);
      miscompares++;
    end
    step();
    vectors++;
    if (ro_regs[31:24] !== 8'd2) begin
      $display("FAIL post_clr_cnt: got %h expected 02", ro_regs[31:24]);
      miscompares++;
    end
    rw_regs[7:0] = 8'h02;
    step();
    vectors++;
    if (ro_regs[7:0] !== 8'h02 || ro_regs[31:24] !== 8'd2) begin
      $display("FAIL stop: got ro0=%h ro3=%h expected 02 02", ro_regs[7:0], ro_regs[31:24]);
      miscompares++;
    end
    rw_regs[7:0] = 8'h06;
    step();
    vectors++;
    if (ro_regs[7:0] !== 8'h00 || ro_regs[31:24] !== 8'd0) begin
      $display("FAIL clr_idle: got ro0=%h ro3=%h expected 00 00", ro_regs[7:0], ro_regs[31:24]);
      miscompares++;
    end
  endtask

  task automatic test_capture_compare();
    apply_reset();
    set_cfg(8'h03, 8'd0, 16'hFFFF, 16'h0005);
    for (int i = 1; i <= 292; i++) begin
      step();
      vectors++;
      if (irq !== (i == 6)) begin
        $display("FAIL cmp_irq: cycle %0d got %b expected %b", i, irq, (i == 6));
        miscompares++;
      end
    end
    rw_regs[7:0] = 8'h0B;
    step();
    vectors++;
    if (ro_regs[15:8] !== 8'h23 || ro_regs[23:16] !== 8'h01 || ro_regs[7:0] !== 8'h05) begin
      $display("FAIL capture: got ro1=%h ro2=%h ro0=%h expected 23 01 05",
               ro_regs[15:8], ro_regs[23:16], ro_regs[7:0]);
      miscompares++;
    end
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if (ro_regs[23:8] !== 16'h0123) begin
        $display("FAIL snap_stable: cycle %0d got %h expected 0123", i, ro_regs[23:8]);
        miscompares++;
      end
    end
    ena          = 1'b0;
    rw_regs[7:0] = 8'h03;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (irq !== 1'b0 || ro_regs[23:8] !== 16'h0123) begin
        $display("FAIL ena_hold: cycle %0d got irq=%b snap=%h expected 0 0123", i, irq, ro_regs[23:8]);
        miscompares++;
      end
    end
    ena = 1'b1;
    step();
    rw_regs[7:0] = 8'h0B;
    step();
    vectors++;
    if (ro_regs[23:8] !== 16'h0139) begin
      $display("FAIL freeze_capture: got %h expected 0139", ro_regs[23:8]);
      miscompares++;
    end
  endtask

  task automatic test_pwm();
    logic exp_pwm;
    int   k;
    apply_reset();
    set_cfg(8'h03, 8'd0, 16'd9, 16'd3);
    k       = 0;
    exp_pwm = 1'b0;
    for (int i = 0; i < 31; i++) begin
      step();
      k++;
`ifdef TIMER_PWM_EN
      exp_pwm = (k >= 2) && (((k - 2) % 10) < 3);
`else
      exp_pwm = 1'b0;
`endif
      vectors++;
      if (pwm_out !== exp_pwm) begin
        $display("FAIL pwm_pol0: step %0d got %b expected %b", k, pwm_out, exp_pwm);
        miscompares++;
      end
    end
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (pwm_out !== exp_pwm || irq !== 1'b0) begin
        $display("FAIL pwm_freeze: cycle %0d got pwm=%b irq=%b expected %b 0", i, pwm_out, irq, exp_pwm);
        miscompares++;
      end
    end
    ena = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      k++;
`ifdef TIMER_PWM_EN
      exp_pwm = (k >= 2) && (((k - 2) % 10) < 3);
`else
      exp_pwm = 1'b0;
`endif
      vectors++;
      if (pwm_out !== exp_pwm) begin
        $display("FAIL pwm_resume: step %0d got %b expected %b", k, pwm_out, exp_pwm);
        miscompares++;
      end
    end
    apply_reset();
    set_cfg(8'h13, 8'd0, 16'd9, 16'd3);
    for (int j = 1; j <= 30; j++) begin
      step();
`ifdef TIMER_PWM_EN
      exp_pwm = !((j >= 2) && (((j - 2) % 10) < 3));
`else
      exp_pwm = 1'b0;
`endif
      vectors++;
      if (pwm_out !== exp_pwm) begin
        $display("FAIL pwm_pol1: step %0d got %b expected %b", j, pwm_out, exp_pwm);
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    ena         = 1'b1;
    rw_regs     = 64'd0;
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_saturation_clear();
    test_capture_compare();
    test_pwm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
